// File: rtl/fp_booth_mult_seq.sv
// Sequential floating-point multiplier: radix-2 Booth significand multiply, one step per cycle,
// with zero/special fast path, truncating normalisation and overflow/underflow/exception flags.
module fp_booth_mult_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   exception
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam int CW = $clog2(N);
  localparam logic signed [EXP_W+1:0] BIAS    = (2 ** (EXP_W - 1)) - 1;
  localparam logic signed [EXP_W+1:0] EXP_MAX = (2 ** EXP_W) - 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [CW-1:0]             r_step;
  logic signed [N-1:0]       r_acc_hi, r_mcand, w_booth_sum;
  logic [N-1:0]              r_acc_lo;
  logic                      r_qm1;
  logic                      r_sign;
  logic signed [EXP_W+1:0]   r_exp_sum, w_exp;
  logic                      r_a_zero, r_b_zero, r_a_inf, r_b_inf, r_a_nan, r_b_nan;
  logic [W-1:0]              r_result, w_res;
  logic                      r_ovf, r_unf, r_exc, r_out_valid;
  logic                      w_ovf, w_unf, w_exc;

  logic [EXP_W-1:0]          w_a_exp, w_b_exp;
  logic [MAN_W-1:0]          w_a_man, w_b_man, w_man;
  logic                      w_a_zero, w_b_zero, w_a_spec, w_b_spec, w_fast, w_accept;
  logic [PW-1:0]             w_prod;
  logic                      w_norm, w_unused_lsbs;

  assign w_a_exp  = a[W-2:MAN_W];
  assign w_b_exp  = b[W-2:MAN_W];
  assign w_a_man  = a[MAN_W-1:0];
  assign w_b_man  = b[MAN_W-1:0];
  assign w_a_zero = (w_a_exp == '0);
  assign w_b_zero = (w_b_exp == '0);
  assign w_a_spec = &w_a_exp;
  assign w_b_spec = &w_b_exp;
  assign w_fast   = w_a_zero | w_b_zero | w_a_spec | w_b_spec;
  assign w_accept = in_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = w_fast ? S_NORM : S_MUL;
      S_MUL:  if (r_step == CW'(N - 1)) w_state_nxt = S_NORM;
      S_NORM: w_state_nxt = S_DONE;
      S_DONE: if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Booth recoding of the multiplier LSB pair {Q0, Q-1}
  always_comb begin
    w_booth_sum = r_acc_hi;
    case ({r_acc_lo[0], r_qm1})
      2'b01:   w_booth_sum = r_acc_hi + r_mcand;
      2'b10:   w_booth_sum = r_acc_hi - r_mcand;
      default: w_booth_sum = r_acc_hi;
    endcase
  end

  // Both significands are positive, so the top two accumulator bits never carry product data
  assign w_prod        = {r_acc_hi[N-3:0], r_acc_lo};
  assign w_norm        = w_prod[PW-1];
  assign w_man         = w_norm ? w_prod[PW-2 -: MAN_W] : w_prod[PW-3 -: MAN_W];
  assign w_unused_lsbs = ^w_prod[MAN_W-1:0];
  assign w_exp         = r_exp_sum + $signed({{(EXP_W+1){1'b0}}, w_norm});

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_exc = 1'b0;
    if (r_a_nan || r_b_nan || ((r_a_inf || r_b_inf) && (r_a_zero || r_b_zero))) begin
      w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_exc = 1'b1;
    end else if (r_a_inf || r_b_inf) begin
      w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_exc = 1'b1;
    end else if (r_a_zero || r_b_zero) begin
      w_res = {r_sign, {(W-1){1'b0}}};
    end else if (w_exp >= EXP_MAX) begin
      w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ovf = 1'b1;
    end else if (w_exp[EXP_W+1] || (w_exp == '0)) begin
      w_res = {r_sign, {(W-1){1'b0}}};
      w_unf = 1'b1;
    end else begin
      w_res = {r_sign, w_exp[EXP_W-1:0], w_man};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step      <= '0;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
      r_qm1       <= 1'b0;
      r_mcand     <= '0;
      r_sign      <= 1'b0;
      r_exp_sum   <= '0;
      r_a_zero    <= 1'b0;
      r_b_zero    <= 1'b0;
      r_a_inf     <= 1'b0;
      r_b_inf     <= 1'b0;
      r_a_nan     <= 1'b0;
      r_b_nan     <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_exc       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_step    <= '0;
        r_acc_hi  <= '0;
        r_acc_lo  <= {2'b01, w_b_man};
        r_qm1     <= 1'b0;
        r_mcand   <= {2'b01, w_a_man};
        r_sign    <= a[W-1] ^ b[W-1];
        r_exp_sum <= $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - BIAS;
        r_a_zero  <= w_a_zero;
        r_b_zero  <= w_b_zero;
        r_a_inf   <= w_a_spec && (w_a_man == '0);
        r_b_inf   <= w_b_spec && (w_b_man == '0);
        r_a_nan   <= w_a_spec && (w_a_man != '0);
        r_b_nan   <= w_b_spec && (w_b_man != '0);
        r_result  <= '0;
        r_ovf     <= 1'b0;
        r_unf     <= 1'b0;
        r_exc     <= 1'b0;
      end
      if (r_state == S_MUL) begin
        r_acc_hi <= {w_booth_sum[N-1], w_booth_sum[N-1:1]};
        r_acc_lo <= {w_booth_sum[0], r_acc_lo[N-1:1]};
        r_qm1    <= r_acc_lo[0];
        r_step   <= r_step + CW'(1);
      end
      if (r_state == S_NORM) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_unf    <= w_unf;
        r_exc    <= w_exc;
      end
      // out_valid rises one cycle after DONE is entered and drops on the handshake edge
      if (r_state == S_DONE) r_out_valid <= !(r_out_valid && out_ready);
      else                   r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign exception = r_exc;
endmodule

// File: tb/tb_fp_booth_mult_seq.sv
// Directed bench for fp_booth_mult_seq: single precision instance plus a 5/10-bit instance.
module tb_fp_booth_mult_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, ovf8, unf8, exc8;
  logic [31:0] a8, b8, res8;
  logic        in_valid5, in_ready5, out_valid5, out_ready5, ovf5, unf5, exc5;
  logic [15:0] a5, b5, res5;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  fp_booth_mult_seq #(.EXP_W(8), .MAN_W(23)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(res8), .overflow(ovf8), .underflow(unf8), .exception(exc8));

  fp_booth_mult_seq #(.EXP_W(5), .MAN_W(10)) dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid5), .in_ready(in_ready5),
    .a(a5), .b(b5), .out_valid(out_valid5), .out_ready(out_ready5),
    .result(res5), .overflow(ovf5), .underflow(unf5), .exception(exc5));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle; flags are {overflow, underflow, exception}
  task automatic op8(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                     input int exp_lat, input logic [31:0] exp_res, input logic [2:0] exp_flags,
                     input int hold);
    int n;
    a8 = ia; b8 = ib; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = '1; b8 = '1;
    check({tag, "_busy"}, {31'd0, in_ready8}, 32'd0);
    n = 0;
    while (!out_valid8 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, res8, exp_res);
    check({tag, "_flags"}, {29'd0, ovf8, unf8, exc8}, {29'd0, exp_flags});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      check({tag, "_hold_vld"}, {31'd0, out_valid8}, 32'd1);
      check({tag, "_hold_res"}, res8, exp_res);
      check({tag, "_hold_rdy"}, {31'd0, in_ready8}, 32'd0);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check({tag, "_vld_drop"}, {31'd0, out_valid8}, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, in_ready8}, 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    in_valid5 = 1'b0; out_ready5 = 1'b0; a5 = '0; b5 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready8}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
    check("rst_result", res8, 32'd0);
    check("rst_flags", {29'd0, ovf8, unf8, exc8}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    op8("mul_5p125", 32'h40A40000, 32'hC0F00000, 27, 32'hC219C000, 3'b000, 0);
    op8("mul_neg_neg", 32'hC1440000, 32'hC0900000, 27, 32'h425C8000, 3'b000, 5);
    op8("zero_b", 32'h3D000000, 32'h00000000, 2, 32'h00000000, 3'b000, 0);
    op8("negzero", 32'hBF800000, 32'h00000000, 2, 32'h80000000, 3'b000, 0);
    op8("denorm_flush", 32'h00400000, 32'h3F800000, 2, 32'h00000000, 3'b000, 0);
    op8("ovf_big", 32'h7F000000, 32'h7F000000, 27, 32'h7F800000, 3'b100, 0);
    op8("ovf_edge", 32'h7F000000, 32'h40000000, 27, 32'h7F800000, 3'b100, 0);
    op8("no_ovf_edge", 32'h7F000000, 32'h3F800000, 27, 32'h7F000000, 3'b000, 0);
    op8("nan_in", 32'h7FC00000, 32'h3F800000, 2, 32'h7FC00000, 3'b001, 0);
    op8("inf_x_zero", 32'h7F800000, 32'h00000000, 2, 32'h7FC00000, 3'b001, 0);
    op8("neg_inf", 32'hFF800000, 32'h3F800000, 2, 32'hFF800000, 3'b001, 0);
    op8("unf_small", 32'h00800000, 32'h00800000, 27, 32'h00000000, 3'b010, 0);
    op8("unf_edge", 32'h00800000, 32'h3F000000, 27, 32'h00000000, 3'b010, 0);

    // Abort an operation at MUL step 10
    a8 = 32'h40A40000; b8 = 32'hC0F00000; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_out_valid", {31'd0, out_valid8}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready8}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    op8("after_abort", 32'h3F800000, 32'hC0E00000, 27, 32'hC0E00000, 3'b000, 0);

    a5 = 16'h4000; b5 = 16'h4380; in_valid5 = 1'b1;
    @(posedge clk); #1;
    in_valid5 = 1'b0;
    n = 0;
    while (!out_valid5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("half_lat", n, 32'd14);
    check("half_res", {16'd0, res5}, 32'h00004780);
    check("half_flags", {29'd0, ovf5, unf5, exc5}, 32'd0);
    out_ready5 = 1'b1;
    @(posedge clk); #1;
    out_ready5 = 1'b0;
    check("half_vld_drop", {31'd0, out_valid5}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
